// File: rtl/mxbus_ram_wait_if.sv
// MX Bus dual-channel RAM slave bundle: one write channel and one read channel
// sharing nothing but the clock domain.
interface mxbus_ram_wait_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  s0_wr_txn_start;
    logic [DATA_WIDTH-1:0] s0_wr_data;
    logic [STRB_WIDTH-1:0] s0_wr_strb;
    logic [ADDR_WIDTH-1:0] s0_wr_addr;
    logic                  s0_wr_ready;
    logic                  s0_wr_txn_ack;
    logic                  s0_wr_txn_cpl;

    logic                  s0_rd_txn_start;
    logic [ADDR_WIDTH-1:0] s0_rd_addr;
    logic                  s0_rd_ready;
    logic [DATA_WIDTH-1:0] s0_rd_data;
    logic                  s0_rd_txn_ack;
    logic                  s0_rd_txn_cpl;

    modport master (
        output s0_wr_txn_start, s0_wr_data, s0_wr_strb, s0_wr_addr,
        input  s0_wr_ready, s0_wr_txn_ack, s0_wr_txn_cpl,
        output s0_rd_txn_start, s0_rd_addr,
        input  s0_rd_ready, s0_rd_data, s0_rd_txn_ack, s0_rd_txn_cpl
    );

    modport slave (
        input  s0_wr_txn_start, s0_wr_data, s0_wr_strb, s0_wr_addr,
        output s0_wr_ready, s0_wr_txn_ack, s0_wr_txn_cpl,
        input  s0_rd_txn_start, s0_rd_addr,
        output s0_rd_ready, s0_rd_data, s0_rd_txn_ack, s0_rd_txn_cpl
    );
endinterface

// File: rtl/mxbus_ram_wait.sv
// MX Bus RAM slave with independent read/write channels, programmable wait
// states, byte-lane strobes and a selectable same-address collision policy.
module mxbus_ram_wait #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned WR_LATENCY     = 1,
    parameter int unsigned COLLISION_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    mxbus_ram_wait_if.slave  s0
);
    localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH  = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_WIDTH-1:0] RD_CNT_INIT = CNT_WIDTH'(RD_LATENCY - 2);
    localparam logic [CNT_WIDTH-1:0] WR_CNT_INIT = CNT_WIDTH'(WR_LATENCY - 2);

    if (RD_LATENCY < 1 || RD_LATENCY > 16) begin : g_bad_rd_latency
        $error("mxbus_ram_wait: RD_LATENCY must be in 1..16");
    end
    if (WR_LATENCY < 1 || WR_LATENCY > 16) begin : g_bad_wr_latency
        $error("mxbus_ram_wait: WR_LATENCY must be in 1..16");
    end
    if (DATA_WIDTH == 0 || (DATA_WIDTH % 8) != 0) begin : g_bad_data_width
        $error("mxbus_ram_wait: DATA_WIDTH must be a non-zero multiple of 8");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [1:0]            rd_state_q, rd_state_d;
    logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  rd_ready_q, rd_ready_d;
    logic                  rd_ack_q, rd_ack_d;
    logic                  rd_cpl_q, rd_cpl_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_sample_c;
    logic [ADDR_WIDTH-1:0] rd_sample_addr_c;
    logic [DATA_WIDTH-1:0] rd_word_c;

    logic [1:0]            wr_state_q, wr_state_d;
    logic [CNT_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [STRB_WIDTH-1:0] wr_strb_q, wr_strb_d;
    logic                  wr_ready_q, wr_ready_d;
    logic                  wr_ack_q, wr_ack_d;
    logic                  wr_cpl_q, wr_cpl_d;
    logic                  wr_commit_c;
    logic [ADDR_WIDTH-1:0] wr_commit_addr_c;
    logic [DATA_WIDTH-1:0] wr_commit_data_c;
    logic [STRB_WIDTH-1:0] wr_commit_strb_c;

    // Read channel next state; with latency 1 the sample happens on the acceptance edge itself.
    always_comb begin
        rd_state_d       = rd_state_q;
        rd_cnt_d         = rd_cnt_q;
        rd_addr_d        = rd_addr_q;
        rd_ack_d         = 1'b0;
        rd_sample_c      = 1'b0;
        rd_sample_addr_c = rd_addr_q;
        case (rd_state_q)
            ST_IDLE: begin
                if (s0.s0_rd_txn_start) begin
                    rd_addr_d = s0.s0_rd_addr;
                    rd_ack_d  = 1'b1;
                    if (RD_LATENCY == 1) begin
                        rd_state_d       = ST_DONE;
                        rd_sample_c      = 1'b1;
                        rd_sample_addr_c = s0.s0_rd_addr;
                    end else begin
                        rd_state_d = ST_WAIT;
                        rd_cnt_d   = RD_CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (rd_cnt_q == '0) begin
                    rd_state_d  = ST_DONE;
                    rd_sample_c = 1'b1;
                end else begin
                    rd_cnt_d = rd_cnt_q - CNT_WIDTH'(1);
                end
            end
            ST_DONE: rd_state_d = ST_IDLE;
            default: rd_state_d = ST_IDLE;
        endcase
        rd_ready_d = (rd_state_d == ST_IDLE);
        rd_cpl_d   = (rd_state_d == ST_DONE);
    end

    // Write channel next state; commit coincides with entry into DONE.
    always_comb begin
        wr_state_d       = wr_state_q;
        wr_cnt_d         = wr_cnt_q;
        wr_addr_d        = wr_addr_q;
        wr_data_d        = wr_data_q;
        wr_strb_d        = wr_strb_q;
        wr_ack_d         = 1'b0;
        wr_commit_c      = 1'b0;
        wr_commit_addr_c = wr_addr_q;
        wr_commit_data_c = wr_data_q;
        wr_commit_strb_c = wr_strb_q;
        case (wr_state_q)
            ST_IDLE: begin
                if (s0.s0_wr_txn_start) begin
                    wr_addr_d = s0.s0_wr_addr;
                    wr_data_d = s0.s0_wr_data;
                    wr_strb_d = s0.s0_wr_strb;
                    wr_ack_d  = 1'b1;
                    if (WR_LATENCY == 1) begin
                        wr_state_d       = ST_DONE;
                        wr_commit_c      = 1'b1;
                        wr_commit_addr_c = s0.s0_wr_addr;
                        wr_commit_data_c = s0.s0_wr_data;
                        wr_commit_strb_c = s0.s0_wr_strb;
                    end else begin
                        wr_state_d = ST_WAIT;
                        wr_cnt_d   = WR_CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wr_cnt_q == '0) begin
                    wr_state_d  = ST_DONE;
                    wr_commit_c = 1'b1;
                end else begin
                    wr_cnt_d = wr_cnt_q - CNT_WIDTH'(1);
                end
            end
            ST_DONE: wr_state_d = ST_IDLE;
            default: wr_state_d = ST_IDLE;
        endcase
        wr_ready_d = (wr_state_d == ST_IDLE);
        wr_cpl_d   = (wr_state_d == ST_DONE);
    end

    // Read word, optionally forwarding a same-edge write into the returned data.
    always_comb begin
        rd_word_c = mem_q[rd_sample_addr_c];
        if (COLLISION_MODE == 1 && wr_commit_c && (wr_commit_addr_c == rd_sample_addr_c)) begin
            for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
                if (wr_commit_strb_c[i]) begin
                    rd_word_c[8*i +: 8] = wr_commit_data_c[8*i +: 8];
                end
            end
        end
        rd_data_d = rd_sample_c ? rd_word_c : rd_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= ST_IDLE;
            rd_cnt_q   <= '0;
            rd_addr_q  <= '0;
            rd_ready_q <= 1'b1;
            rd_ack_q   <= 1'b0;
            rd_cpl_q   <= 1'b0;
            rd_data_q  <= '0;
            wr_state_q <= ST_IDLE;
            wr_cnt_q   <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_strb_q  <= '0;
            wr_ready_q <= 1'b1;
            wr_ack_q   <= 1'b0;
            wr_cpl_q   <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_addr_q  <= rd_addr_d;
            rd_ready_q <= rd_ready_d;
            rd_ack_q   <= rd_ack_d;
            rd_cpl_q   <= rd_cpl_d;
            rd_data_q  <= rd_data_d;
            wr_state_q <= wr_state_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_strb_q  <= wr_strb_d;
            wr_ready_q <= wr_ready_d;
            wr_ack_q   <= wr_ack_d;
            wr_cpl_q   <= wr_cpl_d;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_commit_c) begin
            for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
                if (wr_commit_strb_c[i]) begin
                    mem_q[wr_commit_addr_c][8*i +: 8] <= wr_commit_data_c[8*i +: 8];
                end
            end
        end
    end

    assign s0.s0_rd_ready   = rd_ready_q;
    assign s0.s0_rd_txn_ack = rd_ack_q;
    assign s0.s0_rd_txn_cpl = rd_cpl_q;
    assign s0.s0_rd_data    = rd_data_q;
    assign s0.s0_wr_ready   = wr_ready_q;
    assign s0.s0_wr_txn_ack = wr_ack_q;
    assign s0.s0_wr_txn_cpl = wr_cpl_q;

endmodule
